// File: rtl/aes_single_round.sv
// rtl/aes_single_round.sv - one AES-128 middle round (SubBytes, ShiftRows, MixColumns, AddRoundKey), registered output
`timescale 1ns/1ps

module aes_single_round (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic [127:0] cypher
);

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] s;
    s = 8'h00;
    case (b)
      8'h00: s = 8'h63;  8'h01: s = 8'h7c;  8'h02: s = 8'h77;  8'h03: s = 8'h7b;
      8'h04: s = 8'hf2;  8'h05: s = 8'h6b;  8'h06: s = 8'h6f;  8'h07: s = 8'hc5;
      8'h08: s = 8'h30;  8'h09: s = 8'h01;  8'h0a: s = 8'h67;  8'h0b: s = 8'h2b;
      8'h0c: s = 8'hfe;  8'h0d: s = 8'hd7;  8'h0e: s = 8'hab;  8'h0f: s = 8'h76;
      8'h10: s = 8'hca;  8'h11: s = 8'h82;  8'h12: s = 8'hc9;  8'h13: s = 8'h7d;
      8'h14: s = 8'hfa;  8'h15: s = 8'h59;  8'h16: s = 8'h47;  8'h17: s = 8'hf0;
      8'h18: s = 8'had;  8'h19: s = 8'hd4;  8'h1a: s = 8'ha2;  8'h1b: s = 8'haf;
      8'h1c: s = 8'h9c;  8'h1d: s = 8'ha4;  8'h1e: s = 8'h72;  8'h1f: s = 8'hc0;
      8'h20: s = 8'hb7;  8'h21: s = 8'hfd;  8'h22: s = 8'h93;  8'h23: s = 8'h26;
      8'h24: s = 8'h36;  8'h25: s = 8'h3f;  8'h26: s = 8'hf7;  8'h27: s = 8'hcc;
      8'h28: s = 8'h34;  8'h29: s = 8'ha5;  8'h2a: s = 8'he5;  8'h2b: s = 8'hf1;
      8'h2c: s = 8'h71;  8'h2d: s = 8'hd8;  8'h2e: s = 8'h31;  8'h2f: s = 8'h15;
      8'h30: s = 8'h04;  8'h31: s = 8'hc7;  8'h32: s = 8'h23;  8'h33: s = 8'hc3;
      8'h34: s = 8'h18;  8'h35: s = 8'h96;  8'h36: s = 8'h05;  8'h37: s = 8'h9a;
      8'h38: s = 8'h07;  8'h39: s = 8'h12;  8'h3a: s = 8'h80;  8'h3b: s = 8'he2;
      8'h3c: s = 8'heb;  8'h3d: s = 8'h27;  8'h3e: s = 8'hb2;  8'h3f: s = 8'h75;
      8'h40: s = 8'h09;  8'h41: s = 8'h83;  8'h42: s = 8'h2c;  8'h43: s = 8'h1a;
      8'h44: s = 8'h1b;  8'h45: s = 8'h6e;  8'h46: s = 8'h5a;  8'h47: s = 8'ha0;
      8'h48: s = 8'h52;  8'h49: s = 8'h3b;  8'h4a: s = 8'hd6;  8'h4b: s = 8'hb3;
      8'h4c: s = 8'h29;  8'h4d: s = 8'he3;  8'h4e: s = 8'h2f;  8'h4f: s = 8'h84;
      8'h50: s = 8'h53;  8'h51: s = 8'hd1;  8'h52: s = 8'h00;  8'h53: s = 8'hed;
      8'h54: s = 8'h20;  8'h55: s = 8'hfc;  8'h56: s = 8'hb1;  8'h57: s = 8'h5b;
      8'h58: s = 8'h6a;  8'h59: s = 8'hcb;  8'h5a: s = 8'hbe;  8'h5b: s = 8'h39;
      8'h5c: s = 8'h4a;  8'h5d: s = 8'h4c;  8'h5e: s = 8'h58;  8'h5f: s = 8'hcf;
      8'h60: s = 8'hd0;  8'h61: s = 8'hef;  8'h62: s = 8'haa;  8'h63: s = 8'hfb;
      8'h64: s = 8'h43;  8'h65: s = 8'h4d;  8'h66: s = 8'h33;  8'h67: s = 8'h85;
      8'h68: s = 8'h45;  8'h69: s = 8'hf9;  8'h6a: s = 8'h02;  8'h6b: s = 8'h7f;
      8'h6c: s = 8'h50;  8'h6d: s = 8'h3c;  8'h6e: s = 8'h9f;  8'h6f: s = 8'ha8;
      8'h70: s = 8'h51;  8'h71: s = 8'ha3;  8'h72: s = 8'h40;  8'h73: s = 8'h8f;
      8'h74: s = 8'h92;  8'h75: s = 8'h9d;  8'h76: s = 8'h38;  8'h77: s = 8'hf5;
      8'h78: s = 8'hbc;  8'h79: s = 8'hb6;  8'h7a: s = 8'hda;  8'h7b: s = 8'h21;
      8'h7c: s = 8'h10;  8'h7d: s = 8'hff;  8'h7e: s = 8'hf3;  8'h7f: s = 8'hd2;
      8'h80: s = 8'hcd;  8'h81: s = 8'h0c;  8'h82: s = 8'h13;  8'h83: s = 8'hec;
      8'h84: s = 8'h5f;  8'h85: s = 8'h97;  8'h86: s = 8'h44;  8'h87: s = 8'h17;
      8'h88: s = 8'hc4;  8'h89: s = 8'ha7;  8'h8a: s = 8'h7e;  8'h8b: s = 8'h3d;
      8'h8c: s = 8'h64;  8'h8d: s = 8'h5d;  8'h8e: s = 8'h19;  8'h8f: s = 8'h73;
      8'h90: s = 8'h60;  8'h91: s = 8'h81;  8'h92: s = 8'h4f;  8'h93: s = 8'hdc;
      8'h94: s = 8'h22;  8'h95: s = 8'h2a;  8'h96: s = 8'h90;  8'h97: s = 8'h88;
      8'h98: s = 8'h46;  8'h99: s = 8'hee;  8'h9a: s = 8'hb8;  8'h9b: s = 8'h14;
      8'h9c: s = 8'hde;  8'h9d: s = 8'h5e;  8'h9e: s = 8'h0b;  8'h9f: s = 8'hdb;
      8'ha0: s = 8'he0;  8'ha1: s = 8'h32;  8'ha2: s = 8'h3a;  8'ha3: s = 8'h0a;
      8'ha4: s = 8'h49;  8'ha5: s = 8'h06;  8'ha6: s = 8'h24;  8'ha7: s = 8'h5c;
      8'ha8: s = 8'hc2;  8'ha9: s = 8'hd3;  8'haa: s = 8'hac;  8'hab: s = 8'h62;
      8'hac: s = 8'h91;  8'had: s = 8'h95;  8'hae: s = 8'he4;  8'haf: s = 8'h79;
      8'hb0: s = 8'he7;  8'hb1: s = 8'hc8;  8'hb2: s = 8'h37;  8'hb3: s = 8'h6d;
      8'hb4: s = 8'h8d;  8'hb5: s = 8'hd5;  8'hb6: s = 8'h4e;  8'hb7: s = 8'ha9;
      8'hb8: s = 8'h6c;  8'hb9: s = 8'h56;  8'hba: s = 8'hf4;  8'hbb: s = 8'hea;
      8'hbc: s = 8'h65;  8'hbd: s = 8'h7a;  8'hbe: s = 8'hae;  8'hbf: s = 8'h08;
      8'hc0: s = 8'hba;  8'hc1: s = 8'h78;  8'hc2: s = 8'h25;  8'hc3: s = 8'h2e;
      8'hc4: s = 8'h1c;  8'hc5: s = 8'ha6;  8'hc6: s = 8'hb4;  8'hc7: s = 8'hc6;
      8'hc8: s = 8'he8;  8'hc9: s = 8'hdd;  8'hca: s = 8'h74;  8'hcb: s = 8'h1f;
      8'hcc: s = 8'h4b;  8'hcd: s = 8'hbd;  8'hce: s = 8'h8b;  8'hcf: s = 8'h8a;
      8'hd0: s = 8'h70;  8'hd1: s = 8'h3e;  8'hd2: s = 8'hb5;  8'hd3: s = 8'h66;
      8'hd4: s = 8'h48;  8'hd5: s = 8'h03;  8'hd6: s = 8'hf6;  8'hd7: s = 8'h0e;
      8'hd8: s = 8'h61;  8'hd9: s = 8'h35;  8'hda: s = 8'h57;  8'hdb: s = 8'hb9;
      8'hdc: s = 8'h86;  8'hdd: s = 8'hc1;  8'hde: s = 8'h1d;  8'hdf: s = 8'h9e;
      8'he0: s = 8'he1;  8'he1: s = 8'hf8;  8'he2: s = 8'h98;  8'he3: s = 8'h11;
      8'he4: s = 8'h69;  8'he5: s = 8'hd9;  8'he6: s = 8'h8e;  8'he7: s = 8'h94;
      8'he8: s = 8'h9b;  8'he9: s = 8'h1e;  8'hea: s = 8'h87;  8'heb: s = 8'he9;
      8'hec: s = 8'hce;  8'hed: s = 8'h55;  8'hee: s = 8'h28;  8'hef: s = 8'hdf;
      8'hf0: s = 8'h8c;  8'hf1: s = 8'ha1;  8'hf2: s = 8'h89;  8'hf3: s = 8'h0d;
      8'hf4: s = 8'hbf;  8'hf5: s = 8'he6;  8'hf6: s = 8'h42;  8'hf7: s = 8'h68;
      8'hf8: s = 8'h41;  8'hf9: s = 8'h99;  8'hfa: s = 8'h2d;  8'hfb: s = 8'h0f;
      8'hfc: s = 8'hb0;  8'hfd: s = 8'h54;  8'hfe: s = 8'hbb;  8'hff: s = 8'h16;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte i lives at bits [127-8i -: 8]; state element s[r][c] is byte r+4c.
  logic [7:0]   sb [16];
  logic [7:0]   sr [16];
  logic [7:0]   mc [16];
  logic [127:0] round_out;

  genvar gi, gr, gc;

  generate
    for (gi = 0; gi < 16; gi++) begin : g_sub
      assign sb[gi] = sbox(plaintext[127-8*gi -: 8]);
      assign round_out[127-8*gi -: 8] = mc[gi] ^ key[127-8*gi -: 8];
    end

    for (gc = 0; gc < 4; gc++) begin : g_col
      for (gr = 0; gr < 4; gr++) begin : g_row
        assign sr[gr+4*gc] = sb[gr+4*((gc+gr)%4)];
      end
    end

    for (gc = 0; gc < 4; gc++) begin : g_mix
      logic [7:0] a0, a1, a2, a3;
      assign a0 = sr[4*gc];
      assign a1 = sr[4*gc+1];
      assign a2 = sr[4*gc+2];
      assign a3 = sr[4*gc+3];
      assign mc[4*gc]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      assign mc[4*gc+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      assign mc[4*gc+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      assign mc[4*gc+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cypher <= '0;
    end else begin
      cypher <= round_out;
    end
  end

endmodule

// File: tb/tb_aes_single_round.sv
// tb/tb_aes_single_round.sv - scoreboard bench for aes_single_round against an algebraic AES round model
`timescale 1ns/1ps

module tb_aes_single_round;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] plaintext = '0;
  logic [127:0] key = '0;
  logic [127:0] cypher;

  localparam logic [127:0] C1_PT  = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] C1_KEY = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] C1_OUT = 128'h89d810e8855ace682d1843d8cb128fe4;
  localparam logic [127:0] ALL63  = {16{8'h63}};

  int n_cmp = 0;
  int n_err = 0;
  logic [127:0] exp_q [$];
  logic [7:0]   sb_model [256];

  always #5 clk = ~clk;

  aes_single_round dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .plaintext (plaintext),
    .key       (key),
    .cypher    (cypher)
  );

  // Carry-less product followed by reduction modulo 0x11b.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box from the multiplicative inverse plus affine transform.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (a != 0 && gf_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sb_model[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [7:0] coef(input int d);
    case (d)
      0: return 8'h02;
      1: return 8'h03;
      default: return 8'h01;
    endcase
  endfunction

  function automatic logic [127:0] model_round(input logic [127:0] pt, input logic [127:0] k);
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [7:0]   o;
    logic [127:0] res;
    res = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        s[r][c] = sb_model[pt[127-8*(r+4*c) -: 8]];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[r][c] = s[r][(c+r)%4];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        o = 8'h00;
        for (int j = 0; j < 4; j++) o = o ^ gf_mul(coef((j - r + 4) % 4), t[j][c]);
        res[127-8*(r+4*c) -: 8] = o ^ k[127-8*(r+4*c) -: 8];
      end
    return res;
  endfunction

  task automatic push_input(input logic [127:0] pt, input logic [127:0] k, input logic [127:0] expv);
    @(negedge clk);
    plaintext = pt;
    key       = k;
    exp_q.push_back(expv);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset();
    logic [127:0] expv;
    rst_n = 1'b0;
    plaintext = rnd128();
    key = rnd128();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (cypher !== 128'h0) begin
        n_err++;
        $display("FAIL reset_hold[%0d]: got %h want %h", i, cypher, 128'h0);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(model_round(plaintext, key));
    @(posedge clk); #1;
    expv = exp_q.pop_front();
    n_cmp++;
    if (cypher !== expv) begin
      n_err++;
      $display("FAIL reset_release: got %h want %h", cypher, expv);
    end
  endtask

  task automatic test_known_vectors();
    logic [127:0] pts [4];
    logic [127:0] keys [4];
    logic [127:0] outs [4];
    logic [127:0] expv;
    pts[0] = '0;                     keys[0] = '0;     outs[0] = ALL63;
    pts[1] = '0;                     keys[1] = '1;     outs[1] = {16{8'h9c}};
    pts[2] = {16{8'h52}};            keys[2] = '0;     outs[2] = '0;
    pts[3] = C1_PT;                  keys[3] = C1_KEY; outs[3] = C1_OUT;
    for (int i = 0; i < 4; i++) begin
      push_input(pts[i], keys[i], outs[i]);
      @(posedge clk); #1;
      expv = exp_q.pop_front();
      n_cmp++;
      if (cypher !== expv) begin
        n_err++;
        $display("FAIL known_vec[%0d]: got %h want %h", i, cypher, expv);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] expv;
    logic [127:0] prev;
    prev = C1_OUT;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) push_input('0, '0, ALL63);
      else            push_input(C1_PT, C1_KEY, C1_OUT);
      #1;
      n_cmp++;
      if (cypher !== prev) begin
        n_err++;
        $display("FAIL b2b_latency[%0d]: got %h want %h", i, cypher, prev);
      end
      @(posedge clk); #1;
      expv = exp_q.pop_front();
      n_cmp++;
      if (cypher !== expv) begin
        n_err++;
        $display("FAIL b2b[%0d]: got %h want %h", i, cypher, expv);
      end
      prev = expv;
    end
  endtask

  task automatic test_midstream_reset();
    logic [127:0] expv;
    push_input(C1_PT, C1_KEY, C1_OUT);
    @(posedge clk); #1;
    expv = exp_q.pop_front();
    n_cmp++;
    if (cypher !== expv) begin
      n_err++;
      $display("FAIL mid_pre: got %h want %h", cypher, expv);
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (cypher !== 128'h0) begin
      n_err++;
      $display("FAIL mid_async_clear: got %h want %h", cypher, 128'h0);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (cypher !== 128'h0) begin
      n_err++;
      $display("FAIL mid_held: got %h want %h", cypher, 128'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    plaintext = '0;
    key = '0;
    exp_q.push_back(ALL63);
    @(posedge clk); #1;
    expv = exp_q.pop_front();
    n_cmp++;
    if (cypher !== expv) begin
      n_err++;
      $display("FAIL mid_resume: got %h want %h", cypher, expv);
    end
  endtask

  task automatic test_random();
    logic [127:0] pt;
    logic [127:0] k;
    logic [127:0] expv;
    for (int i = 0; i < 1001; i++) begin
      if (i == 0) begin
        pt = 128'h0e3634aece7225b6f26b174ed92b5588;
        k  = 128'hdc9037b09b49dfe997fe723f388115a7;
      end else begin
        pt = rnd128();
        k  = rnd128();
      end
      push_input(pt, k, model_round(pt, k));
      @(posedge clk); #1;
      expv = exp_q.pop_front();
      n_cmp++;
      if (cypher !== expv) begin
        n_err++;
        $display("FAIL random[%0d]: pt %h key %h got %h want %h", i, pt, k, cypher, expv);
      end
    end
  endtask

  task automatic test_hold();
    logic [127:0] expv;
    expv = model_round(C1_PT, 128'h0123456789abcdeffedcba9876543210);
    push_input(C1_PT, 128'h0123456789abcdeffedcba9876543210, expv);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (cypher !== expv) begin
        n_err++;
        $display("FAIL hold[%0d]: got %h want %h", i, cypher, expv);
      end
    end
    void'(exp_q.pop_front());
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_known_vectors();
    test_back_to_back();
    test_midstream_reset();
    test_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/aes_single_round.md
Name: aes_single_round

Overview:
- Computes one standard AES-128 middle round (FIPS-197): SubBytes, ShiftRows, MixColumns, then AddRoundKey.
- Used as the round datapath building block of the AES/UART interface, and as a standalone round checker.
- No key expansion: the key input is used directly as the round key.
- Output is registered: one result per clock, fully pipelined with one stage.

Parameters:
- none (block is fixed at AES-128: 128-bit state, 128-bit round key)

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- plaintext  input  128  round input state
- key  input  128  round key XORed after MixColumns
- cypher  output  128  registered round output state

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Byte order:
  - bits [127:120] are byte 0; bits [7:0] are byte 15.
  - State mapping is column-major: s[r][c] = byte(r + 4c), matching FIPS-197 in/out ordering.
  - key uses the same mapping.
- SubBytes: each of the 16 bytes is replaced via the FIPS-197 forward S-box, as a 256-entry constant lookup (combinational, e.g. case/ROM).
  - Anchors: S(00)=63, S(01)=7c, S(52)=00, S(53)=ed, S(ff)=16.
- ShiftRows: row r is rotated left by r byte positions: s'[r][c] = s[r][(c+r) mod 4]. Row 0 is unchanged.
- MixColumns: per column, over GF(2^8) with polynomial x^8+x^4+x^3+x+1 (0x11b).
  - out0 = 2a0^3a1^a2^a3
  - out1 = a0^2a1^3a2^a3
  - out2 = a0^a1^2a2^3a3
  - out3 = 3a0^a1^a2^2a3
  - xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1b : 8'h00); 3b = xtime(b)^b.
- AddRoundKey: result = MixColumns output XOR key, bitwise over all 128 bits.
- Timing:
  - Round logic is purely combinational from plaintext/key.
  - cypher is a 128-bit register loaded on every rising clk edge with the round result.
  - Latency is exactly 1 cycle: inputs stable before edge N give the result on cypher after edge N.
  - There is no enable or valid handshake; new inputs may change every cycle, giving throughput of one round per cycle.
- Reset:
  - While rst_n=0, cypher=128'h0, cleared immediately without waiting for a clock.
  - Reset asserted mid-stream discards the pending result.
  - The first edge after rst_n deasserts loads the round of the current inputs.
- Inputs held constant: cypher holds a constant value on every subsequent edge.
- X/unknown inputs are not sanitized; the output follows the inputs.
- No internal state besides the cypher register.

Test Plan:
- Reset: hold rst_n=0 with arbitrary inputs for 3 cycles -> cypher=0 throughout; deassert, one edge later cypher equals the round result.
- Zero vector: plaintext=0, key=0 -> cypher=63636363636363636363636363636363 one cycle later. Then key=ffffffffffffffffffffffffffffffff -> cypher=9c9c9c9c9c9c9c9c9c9c9c9c9c9c9c9c.
- S-box null: plaintext=52525252525252525252525252525252, key=0 -> cypher=0.
- FIPS-197 C.1 round 1:
  - plaintext=00102030405060708090a0b0c0d0e0f0, key=d6aa74fdd2af72fadaa678f1d6ab76fe
  - -> cypher=89d810e8855ace682d1843d8cb128fe4
- Back-to-back and mid-stream reset:
  - Alternate the C.1 vector and the zero vector on consecutive cycles -> cypher alternates 89d810e8…/6363…63, each exactly one cycle after its input.
  - Pulse rst_n low between edges -> cypher=0 immediately.
- Random regression: plaintext=0e3634aece7225b6f26b174ed92b5588, key=dc9037b09b49dfe997fe723f388115a7, plus ≥1000 random pairs -> cypher matches a software AES round model bit-exactly, one cycle later.
